// File: rtl/iobus_pkg.sv
// Shared types and widths for the PDP-6 IO bus connector.
package iobus_pkg;

  localparam int IOS_W  = 7;
  localparam int WORD_W = 36;
  localparam int PI_W   = 7;
  localparam int CNT_W  = 8;

  // No-device watchdog states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    NODEV = 2'd2
  } wd_state_e;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/iobus_pi_sync.sv
// STAGES-deep synchroniser for one slave's 7-bit PI request vector.
// STAGES = 0 passes the request straight through; a single unused stage is
// still built so the port list and flop array are never empty.
module iobus_pi_sync
  import iobus_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PI_W-1:0] pi_in,
  output logic [PI_W-1:0] pi_out
);

  localparam int DEPTH = (STAGES == 0) ? 1 : STAGES;

  logic [PI_W-1:0] stg_q [DEPTH];
  logic [PI_W-1:0] stg_d [DEPTH];

  // Shift the request one stage per clock
  always_comb begin
    stg_d[0] = pi_in;
    for (int k = 1; k < DEPTH; k++) begin
      stg_d[k] = stg_q[k-1];
    end
  end

  // Synchroniser flops, cleared by the asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        stg_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        stg_q[k] <= stg_d[k];
      end
    end
  end

  assign pi_out = (STAGES == 0) ? pi_in : stg_q[DEPTH-1];

endmodule

// File: rtl/iobus_n_connect.sv
// PDP-6 IO bus fan-out/fan-in between the APR and NSLAVE peripherals.
// Conditioning strobes are gated by device-code decode, read data and
// dr_split are ORed from the selected slaves, PI requests are synchronised
// per slave, and a watchdog flags strobes that address no device.
module iobus_n_connect
  import iobus_pkg::*;
#(
  parameter int                       NSLAVE   = 4,
  parameter logic [IOS_W*NSLAVE-1:0]  DEVCODES = {NSLAVE{7'o0}},
  parameter bit                       DECODE   = 1'b1,
  parameter int                       PI_SYNC  = 2,
  parameter int                       TMO      = 15
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         m_iob_poweron,
  input  logic                         m_iob_reset,
  input  logic                         m_datao_clear,
  input  logic                         m_datao_set,
  input  logic                         m_cono_clear,
  input  logic                         m_cono_set,
  input  logic                         m_iob_fm_datai,
  input  logic                         m_iob_fm_status,
  input  logic                         m_rdi_pulse,
  input  logic [3:9]                   m_ios,
  input  logic [0:35]                  m_iob_write,
  output logic [1:7]                   m_pi_req,
  output logic [0:35]                  m_iob_read,
  output logic                         m_dr_split,
  output logic                         m_rdi_data,
  output logic                         m_nodev,
  output logic [NSLAVE-1:0]            s_datao_clear,
  output logic [NSLAVE-1:0]            s_datao_set,
  output logic [NSLAVE-1:0]            s_cono_clear,
  output logic [NSLAVE-1:0]            s_cono_set,
  output logic [NSLAVE-1:0]            s_iob_fm_datai,
  output logic [NSLAVE-1:0]            s_iob_fm_status,
  output logic [NSLAVE-1:0]            s_rdi_pulse,
  output logic [NSLAVE-1:0]            s_iob_poweron,
  output logic [NSLAVE-1:0]            s_iob_reset,
  output logic [IOS_W*NSLAVE-1:0]      s_ios,
  output logic [WORD_W*NSLAVE-1:0]     s_iob_write,
  input  logic [PI_W*NSLAVE-1:0]       s_pi_req,
  input  logic [WORD_W*NSLAVE-1:0]     s_iob_read,
  input  logic [NSLAVE-1:0]            s_dr_split,
  input  logic [NSLAVE-1:0]            s_rdi_data
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO - 1);

  logic [NSLAVE-1:0] sel;
  logic [WORD_W-1:0] rd_or;
  logic              dr_or;
  logic [PI_W-1:0]   pi_sync [NSLAVE];
  logic [PI_W-1:0]   pi_or;
  logic              strobe;
  logic              hit;

  wd_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              nodev_q, nodev_d;

  // Device select: every slave whose code matches m_ios (or all, when decode is off)
  always_comb begin
    sel = '0;
    for (int i = 0; i < NSLAVE; i++) begin
      sel[i] = !DECODE || (m_ios == DEVCODES[IOS_W*i +: IOS_W]);
    end
  end

  assign s_datao_clear   = sel & {NSLAVE{m_datao_clear}};
  assign s_datao_set     = sel & {NSLAVE{m_datao_set}};
  assign s_cono_clear    = sel & {NSLAVE{m_cono_clear}};
  assign s_cono_set      = sel & {NSLAVE{m_cono_set}};
  assign s_iob_fm_datai  = sel & {NSLAVE{m_iob_fm_datai}};
  assign s_iob_fm_status = sel & {NSLAVE{m_iob_fm_status}};

  assign s_rdi_pulse     = {NSLAVE{m_rdi_pulse}};
  assign s_iob_poweron   = {NSLAVE{m_iob_poweron}};
  assign s_iob_reset     = {NSLAVE{m_iob_reset}};
  assign s_ios           = {NSLAVE{m_ios}};
  assign s_iob_write     = {NSLAVE{m_iob_write}};

  // Fan-in of read data and dr_split from the selected slaves, same cycle
  always_comb begin
    rd_or = m_iob_write;
    dr_or = 1'b0;
    for (int i = 0; i < NSLAVE; i++) begin
      rd_or = rd_or | (s_iob_read[WORD_W*i +: WORD_W] & {WORD_W{sel[i]}});
      dr_or = dr_or | (s_dr_split[i] & sel[i]);
    end
  end

  assign m_iob_read = rd_or;
  assign m_dr_split = dr_or;
  assign m_rdi_data = |s_rdi_data;

  for (genvar g = 0; g < NSLAVE; g++) begin : g_pi
    iobus_pi_sync #(
      .STAGES (PI_SYNC)
    ) u_pi_sync (
      .clk    (clk),
      .rst_n  (reset),
      .pi_in  (s_pi_req[PI_W*g +: PI_W]),
      .pi_out (pi_sync[g])
    );
  end

  // OR of the synchronised PI requests
  always_comb begin
    pi_or = '0;
    for (int i = 0; i < NSLAVE; i++) begin
      pi_or = pi_or | pi_sync[i];
    end
  end

  assign m_pi_req = pi_or;

  assign strobe = m_datao_clear | m_datao_set | m_cono_clear | m_cono_set |
                  m_iob_fm_datai | m_iob_fm_status;
  assign hit    = |sel;

  // Watchdog next state: count consecutive unmatched strobe cycles, IO reset wins
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nodev_d = nodev_q;
    if (m_iob_reset) begin
      state_d = IDLE;
      cnt_d   = '0;
      nodev_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (strobe && !hit) begin
            if (TMO == 1) begin
              state_d = NODEV;
              nodev_d = 1'b1;
            end else begin
              state_d = COUNT;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        COUNT: begin
          if (!strobe || hit) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = NODEV;
            nodev_d = 1'b1;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
        NODEV: begin
          state_d = NODEV;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          nodev_d = 1'b0;
        end
      endcase
    end
  end

  // Watchdog registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      nodev_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nodev_q <= nodev_d;
    end
  end

  assign m_nodev = nodev_q;

endmodule
